// File: rtl/i2s_pkg.sv
// Shared constants, FSM state type and slot bit-mapping helper for the I2S transmitter.
package i2s_pkg;

  localparam int FRAME_BITS  = 64;
  localparam int SLOT_BITS   = 32;
  localparam int SAMPLE_BITS = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Serial bit carried in bit period n: left data in n=1..16, right data in n=33..48, else 0.
  function automatic logic slot_bit(input logic [SLOT_BITS-1:0] word, input logic [5:0] n);
    logic [4:0] idx;
    idx = {~n[5], 4'b0000} - n[4:0] + 5'(SAMPLE_BITS);
    if (n[4:0] == 5'd0 || n[4:0] > 5'(SAMPLE_BITS)) return 1'b0;
    return word[idx];
  endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// Bit-clock divider and 64-period bit counter; launch starts a frame at n=0, clear parks it idle.
module i2s_clock_gen
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       launch,
  output logic       bclk,
  output logic       fall_stb,
  output logic       frame_stb,
  output logic [5:0] bit_idx
);

  localparam int PERIOD = 2 * BCLK_DIV;
  localparam int CW     = $clog2(PERIOD);

  logic [CW-1:0] phase_reg;
  logic [5:0]    n_reg;
  logic          bclk_reg;

  assign fall_stb  = !clear && (phase_reg == CW'(PERIOD - 1));
  assign frame_stb = launch || (fall_stb && n_reg == 6'(FRAME_BITS - 1));
  assign bclk      = bclk_reg;
  assign bit_idx   = n_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= '0;
      n_reg     <= '0;
      bclk_reg  <= 1'b0;
    end else if (launch || clear) begin
      phase_reg <= '0;
      n_reg     <= '0;
      bclk_reg  <= 1'b0;
    end else if (fall_stb) begin
      phase_reg <= '0;
      n_reg     <= n_reg + 6'd1;
      bclk_reg  <= 1'b0;
    end else begin
      phase_reg <= phase_reg + CW'(1);
      if (phase_reg == CW'(BCLK_DIV - 1)) bclk_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/i2s_output.sv
// I2S master transmitter: one-word holding buffer, frame loader and run/drain FSM.
// Define I2S_OUTPUT_MUTE_ON_UNDERRUN_EN to send silence on underrun instead of repeating the last sample.
module i2s_output
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_in,
  input  logic [SLOT_BITS-1:0] audio_in,
  input  logic                 audio_in_stb,
  output logic                 audio_in_ack,
  output logic                 bclk_out,
  output logic                 lrclk_out,
  output logic                 dout_out,
  output logic                 underrun_out,
  output logic                 busy_out
);

  state_t               state_reg, state_next;
  logic                 full_reg;
  logic [SLOT_BITS-1:0] buf_reg, sample_reg;
  logic                 lrclk_reg, dout_reg, underrun_reg, busy_reg;
  logic                 clear, launch, fall_stb, frame_stb, frame_start, write;
  logic [5:0]           bit_idx, next_idx;

  assign clear       = (state_reg == IDLE);
  assign launch      = clear && enable_in;
  // A counter wrap only opens a new frame while still enabled; otherwise it ends the drain.
  assign frame_start = frame_stb && enable_in;
  assign write       = audio_in_stb && !full_reg;
  assign next_idx    = bit_idx + 6'd1;

  i2s_clock_gen #(.BCLK_DIV(BCLK_DIV)) u_clock_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .launch    (launch),
    .bclk      (bclk_out),
    .fall_stb  (fall_stb),
    .frame_stb (frame_stb),
    .bit_idx   (bit_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable_in) state_next = RUN;
      RUN:     if (!enable_in) state_next = frame_stb ? IDLE : DRAIN;
      DRAIN: begin
        if (enable_in)      state_next = RUN;
        else if (frame_stb) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg     <= 1'b0;
      buf_reg      <= '0;
      sample_reg   <= '0;
      lrclk_reg    <= 1'b0;
      dout_reg     <= 1'b0;
      underrun_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      busy_reg     <= (state_next != IDLE);
      underrun_reg <= frame_start && !full_reg;
      if (frame_start && full_reg) begin
        sample_reg <= buf_reg;
        full_reg   <= 1'b0;
      end else begin
`ifdef I2S_OUTPUT_MUTE_ON_UNDERRUN_EN
        if (frame_start) sample_reg <= '0;
`endif
        if (write) begin
          buf_reg  <= audio_in;
          full_reg <= 1'b1;
        end
      end
      if (frame_start) begin
        lrclk_reg <= 1'b0;
        dout_reg  <= 1'b0;
      end else if (fall_stb) begin
        lrclk_reg <= next_idx[5];
        dout_reg  <= slot_bit(sample_reg, next_idx);
      end
    end
  end

  assign audio_in_ack = ~full_reg;
  assign lrclk_out    = lrclk_reg;
  assign dout_out     = dout_reg;
  assign underrun_out = underrun_reg;
  assign busy_out     = busy_reg;

endmodule

// File: tb/tb_i2s_output.sv
// Bench for i2s_output with BCLK_DIV=2; honours I2S_OUTPUT_MUTE_ON_UNDERRUN_EN when defined.
`timescale 1ns/1ps
module tb_i2s_output;

  localparam int DIV   = 2;
  localparam int FRAME = 128 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_in = 1'b0;
  logic [31:0] audio_in = '0;
  logic        audio_in_stb = 1'b0;
  logic        audio_in_ack, bclk_out, lrclk_out, dout_out, underrun_out, busy_out;

  i2s_output #(.BCLK_DIV(DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_in    (enable_in),
    .audio_in     (audio_in),
    .audio_in_stb (audio_in_stb),
    .audio_in_ack (audio_in_ack),
    .bclk_out     (bclk_out),
    .lrclk_out    (lrclk_out),
    .dout_out     (dout_out),
    .underrun_out (underrun_out),
    .busy_out     (busy_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Frame-level model: time since frame start, holding buffer and the sample being sent.
  bit          m_act, m_full, m_under;
  int          m_t;
  logic [31:0] m_buf, m_sample;

  always @(posedge clk or negedge rst_n) begin : model
    bit start;
    if (!rst_n) begin
      m_act <= 0; m_full <= 0; m_under <= 0; m_t <= 0; m_buf <= '0; m_sample <= '0;
    end else begin
      start = enable_in && (!m_act || m_t == FRAME - 1);
      m_under <= start && !m_full;
      if (start) begin
        m_t   <= 0;
        m_act <= 1;
        if (m_full) begin
          m_sample <= m_buf;
          m_full   <= 0;
        end else begin
`ifdef I2S_OUTPUT_MUTE_ON_UNDERRUN_EN
          m_sample <= '0;
`endif
          if (audio_in_stb) begin m_buf <= audio_in; m_full <= 1; end
        end
      end else begin
        if (m_act) begin
          if (m_t == FRAME - 1) m_act <= 0;
          else                  m_t <= m_t + 1;
        end
        if (audio_in_stb && !m_full) begin m_buf <= audio_in; m_full <= 1; end
      end
    end
  end

  // Expected {busy, bclk, lrclk, dout, ack, underrun}.
  function automatic logic [5:0] model_out();
    int   n  = m_t / (2 * DIV);
    int   ph = m_t % (2 * DIV);
    logic d  = 1'b0;
    if (m_act && (n % 32) >= 1 && (n % 32) <= 16)
      d = m_sample[(n < 32) ? 32 - n : 48 - n];
    return {m_act, m_act && ph >= DIV, m_act && n >= 32, d, !m_full, m_under};
  endfunction

  always @(negedge clk)
    check("outputs{busy,bclk,lrclk,dout,ack,underrun}",
          {58'd0, busy_out, bclk_out, lrclk_out, dout_out, audio_in_ack, underrun_out},
          {58'd0, model_out()});

  int cyc = 0, und_cnt = 0, und_last = 0, und_gap = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (underrun_out) begin
      und_cnt++;
      und_gap  = cyc - und_last;
      und_last = cyc;
    end

  function automatic logic [63:0] frame_pat(input logic [31:0] w);
    return {1'b0, w[31:16], 15'd0, 1'b0, w[15:0], 15'd0};
  endfunction

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic write_word(input logic [31:0] w);
    int guard = 0;
    audio_in     = w;
    audio_in_stb = 1'b1;
    while (!audio_in_ack && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("write_ack_wait_in_budget", 64'(guard < 1000), 64'd1);
    @(negedge clk);
    audio_in_stb = 1'b0;
  endtask

  // Sample dout/lrclk on the first clock of each bclk-high half, starting at frame start.
  task automatic capture_frame(output logic [63:0] dv, output logic [63:0] lv);
    dv = '0;
    lv = '0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i % (2 * DIV) == DIV) begin
        dv = {dv[62:0], dout_out};
        lv = {lv[62:0], lrclk_out};
      end
    end
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [63:0] dv, lv, rep;
    int c, u0;

    cycles(3);
    rst_n = 1'b1;
    c = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bclk_out || lrclk_out || dout_out || busy_out || underrun_out || !audio_in_ack) c++;
    end
    check("idle_outputs_nonzero_cycles", c, 0);

    write_word(32'h8001_7FFE);
    check("ack_low_when_full", audio_in_ack, 0);
    enable_in = 1'b1;
    u0 = und_cnt;
    fork
      capture_frame(dv, lv);
      begin
        cycles(8);
        write_word(32'h1111_2222);
        check("ack_low_after_accept", audio_in_ack, 0);
      end
    join
    check("frame1_dout", dv, 64'h40008000_3FFF0000);
    check("frame1_lrclk", lv, 64'h00000000_FFFFFFFF);
    check("frame1_no_underrun", und_cnt - u0, 0);

    fork
      capture_frame(dv, lv);
      begin
        cycles(8);
        write_word(32'h3333_4444);
      end
    join
    check("frame2_dout", dv, frame_pat(32'h1111_2222));
    capture_frame(dv, lv);
    check("frame3_dout", dv, frame_pat(32'h3333_4444));
    check("frames123_no_underrun", und_cnt - u0, 0);

`ifdef I2S_OUTPUT_MUTE_ON_UNDERRUN_EN
    rep = 64'd0;
`else
    rep = 64'h19998000_22220000;
`endif
    capture_frame(dv, lv);
    check("underrun_frame4_dout", dv, rep);
    capture_frame(dv, lv);
    check("underrun_frame5_dout", dv, rep);
    check("underrun_count", und_cnt - u0, 2);
    check("underrun_period", und_gap, FRAME);

    cycles(41);
    enable_in = 1'b0;
    c = 0;
    while (busy_out && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("drain_cycles_to_idle", c, 216);
    cycles(20);
    check("idle_after_drain{bclk,lrclk,dout,busy}",
          {bclk_out, lrclk_out, dout_out, busy_out}, 4'b0000);

    enable_in = 1'b1;
    cycles(41);
    enable_in = 1'b0;
    cycles(120);
    enable_in = 1'b1;
    c = 0;
    repeat (300) begin
      @(negedge clk);
      if (!busy_out) c++;
    end
    check("rerun_busy_gap_cycles", c, 0);

    cycles(52);
    write_word(32'hDEAD_BEEF);
    cycles(81);
    check("pre_reset_bclk_high", bclk_out, 1);
    #2;
    rst_n     = 1'b0;
    enable_in = 1'b0;
    #1;
    check("async_reset{bclk,lrclk,dout,busy,underrun,ack}",
          {bclk_out, lrclk_out, dout_out, busy_out, underrun_out, audio_in_ack}, 6'b000001);
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    enable_in = 1'b1;
    u0 = und_cnt;
    capture_frame(dv, lv);
    check("post_reset_frame_dout", dv, 64'd0);
    check("post_reset_underrun", und_cnt - u0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_output.md
# i2s_output

I2S master transmitter that streams 16-bit stereo audio from the control CPU or the transceiver audio path to an external codec/DAC. It is the transmit counterpart of the external-ADC I2S capture used by the transceiver. It sits in the `clk_50` domain. It accepts one stereo word per frame over the standard stb/ack stream handshake and generates `bclk`, `lrclk` and serial data.

## Interface
- `BCLK_DIV`, default 8: system clocks per bclk half-period. Even, ≥2. At 50 MHz the default gives a 3.125 MHz bclk and fs = 48.828 kHz.
- `clk` in 1: system clock (`clk_50`).
- `rst_n` in 1: asynchronous, active-low reset.
- `enable_in` in 1: run request, normally a bit of the `control` register.
- `audio_in` in 32: `{left[15:0], right[15:0]}`, two's complement.
- `audio_in_stb` in 1: word valid.
- `audio_in_ack` out 1: buffer empty. A transfer occurs on any cycle with `stb && ack`.
- `bclk_out` out 1: bit clock.
- `lrclk_out` out 1: word select. 0 = left, 1 = right.
- `dout_out` out 1: serial data, MSB first.
- `underrun_out` out 1: one-cycle pulse per underrun frame.
- `busy_out` out 1: high while frames are being generated.

## Operation
- One-word holding buffer with a `full` flag. `audio_in_ack = ~full`.
- Frame structure:
  - 64 bclk periods, indexed n = 0..63. Each period starts on a bclk falling edge.
  - bclk is low for the first `BCLK_DIV` clocks of a period and high for the second `BCLK_DIV` clocks.
  - `lrclk_out = n[5]`.
  - `dout_out` carries left bit 15-(n-1) for n = 1..16 and right bit 15-(n-33) for n = 33..48. It is 0 at all other n.
  - This gives the Philips one-bit delay after each lrclk edge.
- Frame load at the first clock of n = 0 (frame-start strobe):
  - If `full`: the buffer moves into the shift register and `full` clears.
  - If empty: an underrun occurs and `underrun_out` pulses. The shift register keeps the last sample, or is zeroed (see Configuration).
- Write and frame-start in the same cycle with the buffer empty:
  - The frame is an underrun.
  - The written word lands in the buffer and goes out in the next frame.
- A write can never coincide with a full buffer, because ack is low whenever the buffer is full.
- State machine:
  - IDLE: bclk = lrclk = dout = 0, dividers cleared, `busy_out` = 0. Goes to RUN when `enable_in` = 1.
  - RUN: generates frames. When `enable_in` = 0 it goes to DRAIN.
  - DRAIN: completes the current frame through n = 63, then goes to IDLE. If `enable_in` returns to 1 during DRAIN, go back to RUN with no break in the frame.
- The buffer accepts words in every state. A word held in IDLE is sent in the first frame after enable.

## Timing
- Reset values: `bclk_out`, `lrclk_out`, `dout_out`, `underrun_out` and `busy_out` = 0. `audio_in_ack` = 1. State = IDLE, buffer empty, shift register = 0.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously). The held word is discarded.
- IDLE→RUN: `busy_out` rises on the clock after `enable_in` is sampled high. The frame-start strobe for n = 0 fires on that same clock.
- All outputs are registered. `dout_out` and `lrclk_out` change only on the clock where bclk falls, or on the frame-start clock. They are stable for `BCLK_DIV` clocks before each bclk rising edge.
- Frame length = 128·`BCLK_DIV` clocks.
- Latency: a word accepted before frame-start appears as the left MSB at `dout_out` 2·`BCLK_DIV` clocks after that frame-start.
- `audio_in_ack` rises on the clock after frame-start consumes the buffer.

## Configuration
- `I2S_OUTPUT_MUTE_ON_UNDERRUN_EN`
  - Defined: an underrun frame transmits all zeros (silence).
  - Undefined: an underrun frame retransmits the previous sample (the shift register is reloaded from its last loaded value).
  - `underrun_out` pulses in both cases.

## Structure
- Package `i2s_pkg` holds:
  - constants `FRAME_BITS` = 64, `SLOT_BITS` = 32, `SAMPLE_BITS` = 16;
  - the state enum {IDLE, RUN, DRAIN}.
- Sub-module `i2s_clock_gen` holds the divider and bit counter. It outputs `bclk`, a falling-edge strobe, bit index n, and the frame-start strobe, and has a synchronous clear used in IDLE.
- The top level holds the buffer, shift logic and FSM.

## Test plan
- All tests use `BCLK_DIV` = 2 (frame = 256 clocks).
- Reset release with `enable_in` = 0:
  - outputs held at 0 and ack = 1 for 1000 clocks;
  - bclk never toggles.
- Write 0x8001_7FFE, then enable:
  - left bits shifted out = 1000_0000_0000_0001;
  - right bits = 0111_1111_1111_1110;
  - lrclk falls at n = 0 and rises at n = 32;
  - MSB is on the bclk period after each lrclk edge;
  - no underrun.
- Back-to-back writes 0x1111_2222 and 0x3333_4444, one per frame:
  - two consecutive frames carry exactly those words;
  - ack is low from acceptance until the following frame-start.
- Enable with no writes:
  - `underrun_out` pulses once per 256 clocks;
  - dout = 0 (macro defined), or repeats 0x3333_4444 (macro undefined).
- Drop `enable_in` at n = 10:
  - frame completes through n = 63, then IDLE with all outputs 0.
  - Re-raise at n = 40 (repeat run): no gap, `busy_out` stays 1.
- Assert `rst_n` low at n = 20 with the buffer full:
  - outputs 0 immediately, ack = 1;
  - after release and enable, the first frame is an underrun.
